// File: rtl/bs_pkg.sv
// Shared definitions for the option batch scheduler: Q16.16 constants,
// request record layout and per-engine state encoding.
package bs_pkg;

    localparam int          FRAC_BITS = 16;
    localparam logic [31:0] ONE       = 32'h0001_0000;

    localparam logic [1:0] ENG_IDLE = 2'd0;
    localparam logic [1:0] ENG_RUN  = 2'd1;
    localparam logic [1:0] ENG_HOLD = 2'd2;

    // Request record, MSB first: S0, K, T, sigma, r, otype, tag.
    function automatic int req_rec_w(input int width, input int tag_w);
        return 5 * width + 1 + tag_w;
    endfunction

endpackage

// File: rtl/option_batch_sched_if.sv
// Request and result channels of the option batch scheduler.
interface option_batch_sched_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int LAT_W = 16
);
    logic                    req_valid;
    logic                    req_ready;
    logic signed [WIDTH-1:0] req_S0;
    logic signed [WIDTH-1:0] req_K;
    logic signed [WIDTH-1:0] req_T;
    logic signed [WIDTH-1:0] req_sigma;
    logic signed [WIDTH-1:0] req_r;
    logic                    req_otype;
    logic [TAG_W-1:0]        req_tag;

    logic                    res_valid;
    logic                    res_ready;
    logic [WIDTH-1:0]        res_price;
    logic [TAG_W-1:0]        res_tag;
    logic [LAT_W-1:0]        res_latency;
    logic                    res_err;

    modport master (
        output req_valid, req_S0, req_K, req_T, req_sigma, req_r, req_otype, req_tag, res_ready,
        input  req_ready, res_valid, res_price, res_tag, res_latency, res_err
    );

    modport slave (
        input  req_valid, req_S0, req_K, req_T, req_sigma, req_r, req_otype, req_tag, res_ready,
        output req_ready, res_valid, res_price, res_tag, res_latency, res_err
    );
endinterface

// File: rtl/bs_req_fifo.sv
// Request FIFO with show-ahead head word and full/empty flags.
module bs_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem[rd_ptr_q[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/option_batch_sched.sv
// Batch scheduler: queues pricing requests, dispatches them round-robin to
// NUM_ENG external engines and returns tagged, latency-stamped results.
module option_batch_sched
    import bs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_ENG = 2,
    parameter int TAG_W   = 4,
    parameter int LAT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    option_batch_sched_if.slave      io,
    output logic [NUM_ENG-1:0]       eng_start,
    output logic [NUM_ENG*WIDTH-1:0] eng_S0,
    output logic [NUM_ENG*WIDTH-1:0] eng_K,
    output logic [NUM_ENG*WIDTH-1:0] eng_T,
    output logic [NUM_ENG*WIDTH-1:0] eng_sigma,
    output logic [NUM_ENG*WIDTH-1:0] eng_r,
    output logic [NUM_ENG-1:0]       eng_otype,
    input  logic [NUM_ENG*WIDTH-1:0] eng_price,
    input  logic [NUM_ENG-1:0]       eng_done,
    output logic                     busy
);
    localparam int REC_W = req_rec_w(WIDTH, TAG_W);
    localparam int EW    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    function automatic logic [EW-1:0] nxt(input logic [EW-1:0] x);
        return EW'((int'(x) + 1) % NUM_ENG);
    endfunction

    logic [REC_W-1:0]        fifo_din, fifo_dout;
    logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic signed [WIDTH-1:0] h_s0, h_k, h_t, h_sigma, h_r;
    logic                    h_otype;
    logic [TAG_W-1:0]        h_tag;
    logic                    h_bad;

    assign io.req_ready = !reset && !fifo_full;
    assign fifo_push    = io.req_valid && io.req_ready;
    assign fifo_din     = {io.req_S0, io.req_K, io.req_T, io.req_sigma, io.req_r,
                           io.req_otype, io.req_tag};

    bs_req_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign {h_s0, h_k, h_t, h_sigma, h_r, h_otype, h_tag} = fifo_dout;
    assign h_bad = h_t[WIDTH-1]     || (h_t == '0)     ||
                   h_sigma[WIDTH-1] || (h_sigma == '0) ||
                   h_s0[WIDTH-1]    || (h_s0 == '0)    ||
                   h_k[WIDTH-1]     || (h_k == '0);

    logic [2*NUM_ENG-1:0]     st_vec;
    logic [NUM_ENG*WIDTH-1:0] price_vec;
    logic [NUM_ENG*TAG_W-1:0] tag_vec;
    logic [NUM_ENG*LAT_W-1:0] latc_vec;
    logic [NUM_ENG-1:0]       eng_busy;

    logic             err_full_q, err_full_d;
    logic [TAG_W-1:0] err_tag_q, err_tag_d;
    logic [EW-1:0]    disp_ptr_q, disp_ptr_d, out_ptr_q, out_ptr_d;
    logic             lock_q, lock_d, sel_err_q, sel_err_d;
    logic [EW-1:0]    sel_idx_q, sel_idx_d;

    logic          disp_found, arb_found, do_dispatch, do_err;
    logic [EW-1:0] disp_idx, arb_idx, cur_idx;
    logic          cur_err, res_valid_w, fire;

    // Descending scan so the candidate nearest the pointer wins.
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        arb_found  = 1'b0;
        arb_idx    = '0;
        for (int k = NUM_ENG - 1; k >= 0; k--) begin
            if (st_vec[2*((int'(disp_ptr_q) + k) % NUM_ENG) +: 2] == ENG_IDLE) begin
                disp_found = 1'b1;
                disp_idx   = EW'((int'(disp_ptr_q) + k) % NUM_ENG);
            end
            if (st_vec[2*((int'(out_ptr_q) + k) % NUM_ENG) +: 2] == ENG_HOLD) begin
                arb_found = 1'b1;
                arb_idx   = EW'((int'(out_ptr_q) + k) % NUM_ENG);
            end
        end
    end

    assign do_dispatch = !fifo_empty && !h_bad && disp_found;
    assign do_err      = !fifo_empty && h_bad && !err_full_q;
    assign fifo_pop    = do_dispatch || do_err;

    // A presented result stays locked until accepted, so res_* cannot shift.
    always_comb begin
        if (lock_q) begin
            cur_idx = sel_idx_q;
            cur_err = sel_err_q;
        end else if (arb_found) begin
            cur_idx = arb_idx;
            cur_err = 1'b0;
        end else begin
            cur_idx = '0;
            cur_err = err_full_q;
        end
    end

    assign res_valid_w = lock_q || arb_found || err_full_q;
    assign fire        = res_valid_w && io.res_ready;

    always_comb begin
        io.res_valid   = res_valid_w;
        io.res_price   = '0;
        io.res_tag     = '0;
        io.res_latency = '0;
        io.res_err     = 1'b0;
        if (res_valid_w) begin
            if (cur_err) begin
                io.res_tag = err_tag_q;
                io.res_err = 1'b1;
            end else begin
                io.res_price   = price_vec[int'(cur_idx)*WIDTH +: WIDTH];
                io.res_tag     = tag_vec[int'(cur_idx)*TAG_W +: TAG_W];
                io.res_latency = latc_vec[int'(cur_idx)*LAT_W +: LAT_W];
            end
        end
    end

    always_comb begin
        err_full_d = err_full_q;
        err_tag_d  = err_tag_q;
        if (fire && cur_err) begin
            err_full_d = 1'b0;
        end
        if (do_err) begin
            err_full_d = 1'b1;
            err_tag_d  = h_tag;
        end
        disp_ptr_d = do_dispatch ? nxt(disp_idx) : disp_ptr_q;
        out_ptr_d  = (fire && !cur_err) ? nxt(cur_idx) : out_ptr_q;
        lock_d     = res_valid_w && !io.res_ready;
        sel_idx_d  = cur_idx;
        sel_err_d  = cur_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_full_q <= 1'b0;
            err_tag_q  <= '0;
            disp_ptr_q <= '0;
            out_ptr_q  <= '0;
            lock_q     <= 1'b0;
            sel_idx_q  <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            err_full_q <= err_full_d;
            err_tag_q  <= err_tag_d;
            disp_ptr_q <= disp_ptr_d;
            out_ptr_q  <= out_ptr_d;
            lock_q     <= lock_d;
            sel_idx_q  <= sel_idx_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign busy = !fifo_empty || (|eng_busy) || err_full_q;

    for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_eng
        logic [1:0]       st_q, st_d;
        logic [LAT_W-1:0] lat_q, lat_d, latc_q, latc_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic [WIDTH-1:0] price_q, price_d;
        logic [WIDTH-1:0] s0_q, s0_d, k_q, k_d, t_q, t_d, sg_q, sg_d, r_q, r_d;
        logic             ot_q, ot_d, start_q, start_d;
        logic             go, drain;

        assign go    = do_dispatch && (disp_idx == EW'(gi));
        assign drain = fire && !cur_err && (cur_idx == EW'(gi));

        // HOLD doubles as the "result slot full" flag for this engine.
        always_comb begin
            st_d    = st_q;
            lat_d   = lat_q;
            latc_d  = latc_q;
            tag_d   = tag_q;
            price_d = price_q;
            s0_d    = s0_q;
            k_d     = k_q;
            t_d     = t_q;
            sg_d    = sg_q;
            r_d     = r_q;
            ot_d    = ot_q;
            start_d = go;
            case (st_q)
                ENG_IDLE: begin
                    if (go) begin
                        st_d  = ENG_RUN;
                        lat_d = '0;
                        tag_d = h_tag;
                        s0_d  = h_s0;
                        k_d   = h_k;
                        t_d   = h_t;
                        sg_d  = h_sigma;
                        r_d   = h_r;
                        ot_d  = h_otype;
                    end
                end
                ENG_RUN: begin
                    if (lat_q != '1) begin
                        lat_d = lat_q + 1'b1;
                    end
                    if (eng_done[gi] && !start_q) begin
                        st_d    = ENG_HOLD;
                        price_d = eng_price[gi*WIDTH +: WIDTH];
                        latc_d  = lat_q;
                    end
                end
                ENG_HOLD: begin
                    if (drain) begin
                        st_d = ENG_IDLE;
                    end
                end
                default: st_d = ENG_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q    <= ENG_IDLE;
                lat_q   <= '0;
                latc_q  <= '0;
                tag_q   <= '0;
                price_q <= '0;
                s0_q    <= '0;
                k_q     <= '0;
                t_q     <= '0;
                sg_q    <= '0;
                r_q     <= '0;
                ot_q    <= 1'b0;
                start_q <= 1'b0;
            end else begin
                st_q    <= st_d;
                lat_q   <= lat_d;
                latc_q  <= latc_d;
                tag_q   <= tag_d;
                price_q <= price_d;
                s0_q    <= s0_d;
                k_q     <= k_d;
                t_q     <= t_d;
                sg_q    <= sg_d;
                r_q     <= r_d;
                ot_q    <= ot_d;
                start_q <= start_d;
            end
        end

        assign st_vec[2*gi +: 2]            = st_q;
        assign price_vec[gi*WIDTH +: WIDTH] = price_q;
        assign tag_vec[gi*TAG_W +: TAG_W]   = tag_q;
        assign latc_vec[gi*LAT_W +: LAT_W]  = latc_q;
        assign eng_busy[gi]                 = (st_q != ENG_IDLE);
        assign eng_start[gi]                = start_q;
        assign eng_otype[gi]                = ot_q;
        assign eng_S0[gi*WIDTH +: WIDTH]    = s0_q;
        assign eng_K[gi*WIDTH +: WIDTH]     = k_q;
        assign eng_T[gi*WIDTH +: WIDTH]     = t_q;
        assign eng_sigma[gi*WIDTH +: WIDTH] = sg_q;
        assign eng_r[gi*WIDTH +: WIDTH]     = r_q;
    end
endmodule

// File: tb/tb_option_batch_sched.sv
// Directed bench for option_batch_sched: fixed-latency engine models and a
// tag-indexed scoreboard of expected results.
module tb_option_batch_sched;
    import bs_pkg::*;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int NUM_ENG = 2;
    localparam int TAG_W   = 4;
    localparam int LAT_W   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    option_batch_sched_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LAT_W(LAT_W)) io ();

    logic [NUM_ENG-1:0]       eng_start, eng_otype, eng_done;
    logic [NUM_ENG-1:0]       model_done = '0;
    logic [NUM_ENG-1:0]       manual_done;
    logic [NUM_ENG*WIDTH-1:0] eng_S0, eng_K, eng_T, eng_sigma, eng_r, eng_price;
    logic                     busy;

    option_batch_sched #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_ENG(NUM_ENG), .TAG_W(TAG_W), .LAT_W(LAT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .io        (io),
        .eng_start (eng_start),
        .eng_S0    (eng_S0),
        .eng_K     (eng_K),
        .eng_T     (eng_T),
        .eng_sigma (eng_sigma),
        .eng_r     (eng_r),
        .eng_otype (eng_otype),
        .eng_price (eng_price),
        .eng_done  (eng_done),
        .busy      (busy)
    );

    // Engine model: done N cycles after the start cycle; N=0 never finishes.
    int lat_cfg [NUM_ENG];
    int cnt     [NUM_ENG] = '{default: 0};
    int starts  [NUM_ENG] = '{default: 0};

    always @(posedge clk) begin
        for (int i = 0; i < NUM_ENG; i++) begin
            if (eng_start[i]) begin
                cnt[i]    <= lat_cfg[i];
                starts[i] <= starts[i] + 1;
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
            end
            model_done[i] <= !eng_start[i] && (cnt[i] == 2);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            eng_price[i*WIDTH +: WIDTH] = eng_S0[i*WIDTH +: WIDTH] + eng_K[i*WIDTH +: WIDTH];
        end
    end

    assign eng_done = model_done | manual_done;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] price;
        logic             err;
        logic [LAT_W-1:0] lat;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic nonpos(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] || (x == '0);
    endfunction

    task automatic push(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] k,
                        input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] sg,
                        input logic [WIDTH-1:0] r, input logic ot,
                        input logic [TAG_W-1:0] tag, input logic [LAT_W-1:0] lat);
        exp_t e;
        bit   ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (io.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("push_ready", 64'(ok), 64'd1);
        if (ok) begin
            io.req_S0    = s0;
            io.req_K     = k;
            io.req_T     = t;
            io.req_sigma = sg;
            io.req_r     = r;
            io.req_otype = ot;
            io.req_tag   = tag;
            io.req_valid = 1'b1;
            @(posedge clk);
            #1 io.req_valid = 1'b0;
            e.tag   = tag;
            e.err   = nonpos(t) || nonpos(sg) || nonpos(s0) || nonpos(k);
            e.price = e.err ? '0 : s0 + k;
            e.lat   = e.err ? '0 : lat;
            sb.push_back(e);
            $display("req  tag=%0d S0=%h K=%h T=%h err_exp=%0d", tag, s0, k, t, e.err);
        end
    endtask

    task automatic get_result(input int budget, output logic [TAG_W-1:0] tag_out);
        bit ok  = 1'b0;
        int idx = -1;
        tag_out = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (io.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("res_valid_timeout", 64'(ok), 64'd1);
        if (ok) begin
            tag_out = io.res_tag;
            foreach (sb[j]) begin
                if (idx < 0 && sb[j].tag == io.res_tag) idx = j;
            end
            chk("res_tag_known", 64'(idx >= 0), 64'd1);
            if (idx >= 0) begin
                chk("res_price",   64'(io.res_price),   64'(sb[idx].price));
                chk("res_err",     64'(io.res_err),     64'(sb[idx].err));
                chk("res_latency", 64'(io.res_latency), 64'(sb[idx].lat));
                sb.delete(idx);
            end
            $display("res  tag=%0d price=%h lat=%0d err=%0d", io.res_tag, io.res_price,
                     io.res_latency, io.res_err);
            io.res_ready = 1'b1;
            @(posedge clk);
            #1 io.res_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_req_ready", 64'(io.req_ready), 64'd0);
        chk("rst_res_valid", 64'(io.res_valid), 64'd0);
        chk("rst_res_price", 64'(io.res_price), 64'd0);
        chk("rst_res_tag",   64'(io.res_tag),   64'd0);
        chk("rst_busy",      64'(busy),         64'd0);
        chk("rst_eng_start", 64'(eng_start),    64'd0);
        chk("rst_eng_s0",    64'(eng_S0),       64'd0);
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        manual_done = '0;
        sb.delete();
        @(negedge clk);
        chk("post_rst_req_ready", 64'(io.req_ready), 64'd1);
    endtask

    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] held_tag;
    int               cyc, s0b, s1b;
    bit               saw_valid;

    initial begin
        reset        = 1'b1;
        io.req_valid = 1'b0;
        io.req_S0    = '0;
        io.req_K     = '0;
        io.req_T     = '0;
        io.req_sigma = '0;
        io.req_r     = '0;
        io.req_otype = 1'b0;
        io.req_tag   = '0;
        io.res_ready = 1'b0;
        manual_done  = '0;
        lat_cfg      = '{10, 10};
        do_reset();

        // Single call: engine 0 only, 13-cycle accept-to-result.
        s0b = starts[0];
        s1b = starts[1];
        push(32'h0014_0000, 32'h0010_0000, ONE, 32'h0000_4CCD, 32'h0000_0666, 1'b0, 4'd3, 16'd10);
        cyc = 0;
        while (!io.res_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_to_valid", 64'(cyc), 64'd13);
        get_result(5, tag);
        chk("first_tag", 64'(tag), 64'd3);
        chk("eng0_starts", 64'(starts[0] - s0b), 64'd1);
        chk("eng1_starts", 64'(starts[1] - s1b), 64'd0);

        // Invalid T: error slot, no dispatch.
        s0b = starts[0];
        s1b = starts[1];
        push(32'h0014_0000, 32'h0010_0000, 32'h0, 32'h0000_4CCD, 32'h0000_0666, 1'b1, 4'd7, 16'd0);
        get_result(50, tag);
        chk("err_tag", 64'(tag), 64'd7);
        chk("err_no_start", 64'((starts[0] - s0b) + (starts[1] - s1b)), 64'd0);

        // Unequal engine latencies reorder the results.
        do_reset();
        lat_cfg = '{20, 5};
        push(2 << FRAC_BITS, ONE, ONE, 32'h0000_4CCD, 32'h0, 1'b0, 4'd1, 16'd20);
        push(3 << FRAC_BITS, ONE, ONE, 32'h0000_4CCD, 32'h0, 1'b1, 4'd2, 16'd5);
        get_result(100, tag);
        chk("order_first", 64'(tag), 64'd2);
        get_result(100, tag);
        chk("order_second", 64'(tag), 64'd1);

        // Backpressure: fill FIFO and both engines with res_ready low.
        do_reset();
        lat_cfg = '{10, 10};
        for (int i = 0; i < DEPTH + NUM_ENG; i++) begin
            push((i + 1) << FRAC_BITS, ONE + i, 2 * ONE, 32'h0000_8000, 32'h0000_0666,
                 1'(i % 2), 4'(i), 16'd10);
        end
        repeat (30) @(negedge clk);
        chk("full_req_ready", 64'(io.req_ready), 64'd0);
        chk("full_busy",      64'(busy),         64'd1);
        held_tag = io.res_tag;
        repeat (5) @(negedge clk);
        chk("hold_valid", 64'(io.res_valid), 64'd1);
        chk("hold_tag",   64'(io.res_tag),   64'(held_tag));
        get_result(10, tag);
        push(11 << FRAC_BITS, ONE, ONE, 32'h0000_8000, 32'h0, 1'b0, 4'(DEPTH + NUM_ENG), 16'd10);
        for (int i = 0; i < DEPTH + NUM_ENG; i++) begin
            get_result(200, tag);
        end
        chk("all_returned", 64'(sb.size()), 64'd0);

        // Reset mid-RUN, then a late done pulse.
        do_reset();
        lat_cfg = '{0, 0};
        push(5 << FRAC_BITS, ONE, ONE, 32'h0000_8000, 32'h0, 1'b0, 4'd5, 16'd0);
        repeat (5) @(negedge clk);
        chk("midrun_busy", 64'(busy), 64'd1);
        do_reset();
        manual_done = '1;
        @(negedge clk);
        manual_done = '0;
        saw_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (io.res_valid) saw_valid = 1'b1;
        end
        chk("late_done_no_valid", 64'(saw_valid), 64'd0);
        chk("late_done_busy",     64'(busy),      64'd0);
        lat_cfg = '{10, 10};
        push(6 << FRAC_BITS, ONE, ONE, 32'h0000_8000, 32'h0, 1'b0, 4'd6, 16'd10);
        get_result(100, tag);
        chk("post_reset_tag", 64'(tag), 64'd6);

        // Latency counter saturation on a very slow engine.
        do_reset();
        lat_cfg = '{0, 0};
        push(9 << FRAC_BITS, ONE, ONE, 32'h0000_8000, 32'h0, 1'b0, 4'd9, 16'hFFFF);
        repeat ((1 << LAT_W) + 5) @(negedge clk);
        chk("slow_no_valid", 64'(io.res_valid), 64'd0);
        manual_done[0] = 1'b1;
        @(negedge clk);
        manual_done = '0;
        get_result(10, tag);
        chk("slow_tag", 64'(tag), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
